// File: rtl/astream_pkg.sv
// Shared definitions for the astream transmit/receive shells.
package astream_pkg;

  localparam int unsigned PAYLOAD_BITS_DEF = 32;
  localparam int unsigned COUNT_BITS_DEF   = 16;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/astream_tx_shell_if.sv
// Link bundle for astream_tx_shell: upstream operator side, downstream receive-shell side and status.
interface astream_tx_shell_if
  import astream_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned COUNT_BITS   = COUNT_BITS_DEF
);
  logic [PAYLOAD_BITS-1:0] din;
  logic                    val_in;
  logic                    ready_upward;
  logic [PAYLOAD_BITS-1:0] dout;
  logic                    val_out;
  logic                    ready_downward;
  logic [COUNT_BITS-1:0]   sent_count;

  modport master (
    output din, val_in, ready_downward,
    input  ready_upward, dout, val_out, sent_count
  );

  modport slave (
    input  din, val_in, ready_downward,
    output ready_upward, dout, val_out, sent_count
  );
endinterface

// File: rtl/astream_skid_buffer.sv
// Two-entry skid buffer: registered output word plus one overflow word, occupancy FSM.
module astream_skid_buffer
  import astream_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    val_in,
  output logic                    ready_upward,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    ready_downward
);

  skid_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] out_q, skid_q;
  logic                    accept, send;
  logic                    load_out, out_from_skid, load_skid;

  // Ready and valid come from registered occupancy only.
  assign ready_upward = reset_n & (state_q != TWO);
  assign out_valid    = (state_q != EMPTY);
  assign accept       = val_in & ready_upward;
  assign send         = out_valid & ready_downward;
  assign out_data     = out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (accept && send) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (send) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Skid word always drains before any new input is taken.
        if (send) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : din;
      if (load_skid) skid_q <= din;
    end
  end

endmodule

// File: rtl/astream_tx_shell.sv
// Transmit shell toward an astream receive shell: skid buffer, ready-qualified val_out, sent-word counter.
// Define ASTREAM_TX_IDLE_ZERO_EN to force dout to zero while no word is held.
module astream_tx_shell
  import astream_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned COUNT_BITS   = COUNT_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  astream_tx_shell_if.slave  bus
);

  logic [PAYLOAD_BITS-1:0] out_data;
  logic                    out_valid;
  logic                    send;
  logic [COUNT_BITS-1:0]   count_q;

  astream_skid_buffer #(
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) u_skid (
    .clk            (clk),
    .reset_n        (reset_n),
    .din            (bus.din),
    .val_in         (bus.val_in),
    .ready_upward   (bus.ready_upward),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .ready_downward (bus.ready_downward)
  );

  // The receiver writes on every val cycle, so never present a word while it is full.
  assign send        = out_valid & bus.ready_downward;
  assign bus.val_out = send;

`ifdef ASTREAM_TX_IDLE_ZERO_EN
  assign bus.dout = out_valid ? out_data : '0;
`else
  assign bus.dout = out_data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count_q <= '0;
    else if (send) count_q <= count_q + COUNT_BITS'(1);
  end

  assign bus.sent_count = count_q;

endmodule

// File: tb/tb_astream_tx_shell.sv
// Directed bench for astream_tx_shell: latency, streaming, stall, toggled ready, async reset, counter wrap.
module tb_astream_tx_shell;
  import astream_pkg::*;

  localparam int unsigned PB = 32;
  localparam int unsigned CB = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  astream_tx_shell_if #(.PAYLOAD_BITS(PB), .COUNT_BITS(CB)) bus ();

  astream_tx_shell #(.PAYLOAD_BITS(PB), .COUNT_BITS(CB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_dout(input string tag, input logic [PB-1:0] last_word);
`ifdef ASTREAM_TX_IDLE_ZERO_EN
    check(tag, 64'(bus.dout), 64'(0));
`else
    check(tag, 64'(bus.dout), 64'(last_word));
`endif
  endtask

  initial begin
    logic [CB-1:0] exp_count;
    int            i;
    int            j;
    int            n;
    logic          acc;

    reset_n            = 1'b0;
    bus.din            = '0;
    bus.val_in         = 1'b0;
    bus.ready_downward = 1'b1;
    exp_count          = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", 64'(bus.ready_upward), 64'(0));
    check("rst_val", 64'(bus.val_out), 64'(0));
    check("rst_dout", 64'(bus.dout), 64'(0));
    check("rst_count", 64'(bus.sent_count), 64'(0));
    reset_n = 1'b1;

    // Single word: one-cycle latency
    bus.val_in = 1'b1;
    bus.din    = 32'hA5A5_0001;
    #1;
    check("t1_ready", 64'(bus.ready_upward), 64'(1));
    check("t1_val_early", 64'(bus.val_out), 64'(0));
    cyc();
    bus.val_in = 1'b0;
    #1;
    check("t1_val", 64'(bus.val_out), 64'(1));
    check("t1_dout", 64'(bus.dout), 64'(32'hA5A5_0001));
    cyc();
    exp_count = exp_count + CB'(1);
    #1;
    check("t1_count", 64'(bus.sent_count), 64'(exp_count));
    check("t1_val_idle", 64'(bus.val_out), 64'(0));
    check_idle_dout("t1_idle_dout", 32'hA5A5_0001);

    // Eight words back-to-back
    for (int k = 0; k < 9; k++) begin
      bus.val_in = (k < 8);
      bus.din    = 32'hB000_0000 + PB'(k);
      #1;
      check("t2_ready", 64'(bus.ready_upward), 64'(1));
      if (k >= 1) begin
        check("t2_val", 64'(bus.val_out), 64'(1));
        check("t2_dout", 64'(bus.dout), 64'(32'hB000_0000 + PB'(k - 1)));
      end
      cyc();
    end
    bus.val_in = 1'b0;
    exp_count  = exp_count + CB'(8);
    #1;
    check("t2_count", 64'(bus.sent_count), 64'(exp_count));

    // Stall with three offered words
    bus.ready_downward = 1'b0;
    bus.val_in         = 1'b1;
    bus.din            = 32'hD000_0001;
    #1;
    check("t3_c0_ready", 64'(bus.ready_upward), 64'(1));
    cyc();
    bus.din = 32'hD000_0002;
    #1;
    check("t3_c1_ready", 64'(bus.ready_upward), 64'(1));
    check("t3_c1_val", 64'(bus.val_out), 64'(0));
    check("t3_c1_dout", 64'(bus.dout), 64'(32'hD000_0001));
    cyc();
    bus.din = 32'hD000_0003;
    #1;
    check("t3_c2_ready", 64'(bus.ready_upward), 64'(0));
    check("t3_c2_val", 64'(bus.val_out), 64'(0));
    cyc();
    #1;
    check("t3_c3_ready", 64'(bus.ready_upward), 64'(0));
    check("t3_c3_dout_hold", 64'(bus.dout), 64'(32'hD000_0001));
    cyc();
    bus.ready_downward = 1'b1;
    #1;
    check("t3_c4_val", 64'(bus.val_out), 64'(1));
    check("t3_c4_dout", 64'(bus.dout), 64'(32'hD000_0001));
    check("t3_c4_ready", 64'(bus.ready_upward), 64'(0));
    cyc();
    #1;
    check("t3_c5_val", 64'(bus.val_out), 64'(1));
    check("t3_c5_dout", 64'(bus.dout), 64'(32'hD000_0002));
    check("t3_c5_ready", 64'(bus.ready_upward), 64'(1));
    cyc();
    bus.val_in = 1'b0;
    #1;
    check("t3_c6_val", 64'(bus.val_out), 64'(1));
    check("t3_c6_dout", 64'(bus.dout), 64'(32'hD000_0003));
    cyc();
    exp_count = exp_count + CB'(3);
    #1;
    check("t3_count", 64'(bus.sent_count), 64'(exp_count));
    check("t3_val_idle", 64'(bus.val_out), 64'(0));

    // Sixteen words with ready_downward toggling every cycle
    i = 0;
    j = 0;
    for (int c = 0; c < 80 && j < 16; c++) begin
      bus.ready_downward = c[0];
      bus.val_in         = (i < 16);
      bus.din            = 32'hC000_0000 + PB'(i);
      #1;
      check("t4_gate", 64'(bus.val_out & ~bus.ready_downward), 64'(0));
      if (bus.val_out) begin
        check("t4_order", 64'(bus.dout), 64'(32'hC000_0000 + PB'(j)));
        j++;
      end
      acc = bus.val_in & bus.ready_upward;
      cyc();
      if (acc) i++;
    end
    bus.val_in         = 1'b0;
    bus.ready_downward = 1'b1;
    exp_count          = exp_count + CB'(16);
    #1;
    check("t4_words", 64'(j), 64'(16));
    check("t4_count", 64'(bus.sent_count), 64'(exp_count));
    check("t4_val_idle", 64'(bus.val_out), 64'(0));

    // Asynchronous reset while two words are held
    bus.ready_downward = 1'b0;
    bus.val_in         = 1'b1;
    bus.din            = 32'hE000_0001;
    cyc();
    bus.din = 32'hE000_0002;
    cyc();
    bus.val_in = 1'b0;
    #1;
    check("t5_two_ready", 64'(bus.ready_upward), 64'(0));
    check("t5_two_dout", 64'(bus.dout), 64'(32'hE000_0001));
    bus.ready_downward = 1'b1;
    reset_n            = 1'b0;
    #1;
    check("t5_rst_val", 64'(bus.val_out), 64'(0));
    check("t5_rst_dout", 64'(bus.dout), 64'(0));
    check("t5_rst_count", 64'(bus.sent_count), 64'(0));
    check("t5_rst_ready", 64'(bus.ready_upward), 64'(0));
    cyc();
    reset_n   = 1'b1;
    exp_count = '0;
    bus.val_in = 1'b1;
    bus.din    = 32'hE000_0010;
    #1;
    check("t5_post_ready", 64'(bus.ready_upward), 64'(1));
    cyc();
    bus.val_in = 1'b0;
    #1;
    check("t5_post_val", 64'(bus.val_out), 64'(1));
    check("t5_post_dout", 64'(bus.dout), 64'(32'hE000_0010));
    cyc();
    exp_count = exp_count + CB'(1);
    #1;
    check("t5_post_count", 64'(bus.sent_count), 64'(exp_count));

    // Counter wrap: bring sent_count to all-ones, then one more send
    n = (1 << CB) - 1 - int'(exp_count);
    for (int k = 0; k < n; k++) begin
      bus.val_in = 1'b1;
      bus.din    = PB'(k);
      cyc();
    end
    bus.val_in = 1'b0;
    cyc();
    exp_count = exp_count + CB'(n);
    #1;
    check("t6_count_max", 64'(bus.sent_count), 64'(16'hFFFF));
    check("t6_val_idle", 64'(bus.val_out), 64'(0));
    check_idle_dout("t6_idle_dout", PB'(n - 1));
    bus.val_in = 1'b1;
    bus.din    = 32'hF000_00F0;
    cyc();
    bus.val_in = 1'b0;
    #1;
    check("t6_last_val", 64'(bus.val_out), 64'(1));
    check("t6_last_dout", 64'(bus.dout), 64'(32'hF000_00F0));
    cyc();
    exp_count = exp_count + CB'(1);
    #1;
    check("t6_wrap", 64'(bus.sent_count), 64'(0));
    check("t6_wrap_model", 64'(bus.sent_count), 64'(exp_count));
    check_idle_dout("t6_idle_dout_end", 32'hF000_00F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/astream_tx_shell.md
Name: astream_tx_shell

Overview:
- Transmit-side shell: takes a leaf operator's val/ready output stream and drives the link into a downstream astream receive shell.
- The receive shell writes its FIFO on every cycle its val input is high, whatever its full state. This block therefore qualifies val_out with ready_downward so no word is ever presented while the receiver is full.
- A 2-entry skid buffer gives registered dout, registered ready_upward, and full 1-word/cycle throughput.

Parameters:
- PAYLOAD_BITS, 32, width of din/dout.
- COUNT_BITS, 16, width of the sent-word counter.

Ports:
- clk  input  1  single clock for all logic.
- reset_n  input  1  asynchronous, active-low reset.
- din  input  PAYLOAD_BITS  payload from the leaf operator.
- val_in  input  1  din valid.
- ready_upward  output  1  block can accept din this cycle.
- dout  output  PAYLOAD_BITS  payload to the receive shell (registered).
- val_out  output  1  word transferred this cycle; equals out_valid AND ready_downward.
- ready_downward  input  1  receive shell not full.
- sent_count  output  COUNT_BITS  words delivered since reset; wraps.

Behaviour:
- Reset: clk and a single async reset, asynchronous and active-low (reset_n). While reset_n=0:
  - state=EMPTY, dout=0, sent_count=0, ready_upward=0, val_out=0.
  - Reset asserted mid-transfer discards both buffered words; nothing is flushed.
- Handshakes:
  - accept = val_in & ready_upward.
  - send = out_valid & ready_downward.
  - val_out is a combinational AND of the registered out_valid and ready_downward. This is the only combinational path through the block.
- Ready: ready_upward = reset_n & (state != TWO); it depends on registered state only. val_in while ready_upward=0 is ignored and din is not captured.
- States (occupancy): EMPTY (out_valid=0), ONE (out register valid), TWO (out and skid both valid).
- EMPTY:
  - accept: out<=din, go to ONE.
  - otherwise stay in EMPTY.
- ONE:
  - accept & send: out<=din, stay in ONE.
  - accept & !send: skid<=din, go to TWO.
  - !accept & send: go to EMPTY.
  - neither: hold.
- TWO:
  - send: out<=skid, go to ONE.
  - otherwise hold; ready_upward=0.
- Latency: a word accepted in cycle N is on dout with out_valid=1 in cycle N+1. It transfers in the first cycle ≥N+1 with ready_downward=1.
- Ordering: strictly FIFO; skid contents always go out before any later din.
- Throughput: 1 word/cycle sustained when ready_downward=1 continuously.
- Stall: dout holds stable while out_valid=1 and ready_downward=0.
- sent_count: +1 on each send; wraps from 2^COUNT_BITS-1 to 0 with no flag.
- Simultaneous accept and send in ONE is a pass-through. Accept is impossible in TWO.

Optional Feature:
- Macro: ASTREAM_TX_IDLE_ZERO_EN.
- Defined: dout is driven 0 whenever out_valid=0, matching the receive shell's idle-zero output.
- Undefined: dout keeps the last transferred word while idle, which saves the output mux.
- Handshake behaviour is identical in both builds.

Decomposition:
- Package astream_pkg holds:
  - 2-bit state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Default PAYLOAD_BITS localparam, shared with the receive shell.
- Sub-module astream_skid_buffer: 2-entry register pair plus occupancy FSM, parameterized by PAYLOAD_BITS.
- The top level adds val_out qualification, sent_count and the optional zero-fill.

Test Plan:
- Reset release, then val_in=1 with din=0xA5A5_0001, ready_downward=1 → dout=0xA5A5_0001 and val_out=1 exactly one cycle later; sent_count=1.
- Stream 8 words back-to-back with ready_downward=1 → 8 consecutive val_out cycles in order, ready_upward stays 1, sent_count=8.
- Hold ready_downward=0 while 3 words are offered → words 1-2 buffered, ready_upward=0 from the cycle after the 2nd accept, 3rd word not captured. Release → words 1 then 2 emitted, then the 3rd accepted.
- Toggle ready_downward every cycle during a 16-word stream → no val_out when ready_downward=0, no loss or duplication, order preserved.
- Assert reset_n=0 in state TWO → val_out, dout, sent_count drop to 0 immediately (asynchronously). After release, the first new word is the next one delivered.
- Preset sent_count via 2^COUNT_BITS-1 sends, then send 1 more → sent_count=0. With ASTREAM_TX_IDLE_ZERO_EN defined, idle dout=0; undefined, dout holds the last word.
